// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, engine state encoding, LANES legality
// check and the forward/inverse S-box tables.
package aes_pkg;

   localparam int AES_BLOCK_W = 128;
   localparam int AES_NBYTES  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Element 0 sits at the MSBs, matching byte 0 = bits 127:120.
   typedef logic [0:AES_NBYTES-1][7:0] block_t;

   function automatic bit lanes_legal(input int lanes);
      return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8) || (lanes == 16);
   endfunction

   localparam logic [0:255][7:0] SBOX_FWD = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [0:255][7:0] SBOX_INV = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

endpackage

// File: rtl/sub_bytes_iter_if.sv
// Block-level valid/ready bus of the SubBytes engine: one input and one output channel.
interface sub_bytes_iter_if;
   import aes_pkg::*;

   logic                   in_valid;
   logic                   in_ready;
   logic [AES_BLOCK_W-1:0] in_data;
   logic                   in_inv;
   logic                   out_valid;
   logic                   out_ready;
   logic [AES_BLOCK_W-1:0] out_data;
   logic                   busy;

   modport master (
      output in_valid, in_data, in_inv, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, in_inv, out_ready,
      output in_ready, out_valid, out_data, busy
   );

endinterface

// File: rtl/aes_sbox_fi.sv
// Combinational byte S-box; inv selects the inverse table.
module aes_sbox_fi
   import aes_pkg::*;
(
   input  logic [7:0] a,
   input  logic       inv,
   output logic [7:0] c
);

   assign c = inv ? SBOX_INV[a] : SBOX_FWD[a];

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: LANES S-boxes rewrite the 16-byte work register in
// place over 16/LANES cycles, then hold the result until downstream takes it.
module sub_bytes_iter
   import aes_pkg::*;
#(
   parameter int LANES = 4
) (
   input logic       clk,
   input logic       rst,
   sub_bytes_iter_if.slave bus
);

   localparam int BEATS = AES_NBYTES / LANES;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

   if (!lanes_legal(LANES)) begin : g_bad_lanes
      $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
   end

   state_t                   state, state_nx;
   logic [CW-1:0]            cnt;
   block_t                   work;
   logic                     inv;
   logic [LANES-1:0][3:0]    idx;
   logic [LANES-1:0][7:0]    lane_in;
   logic [LANES-1:0][7:0]    lane_out;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      idx     = '0;
      lane_in = '0;
      for (int k = 0; k < LANES; k++) begin
         idx[k]     = 4'(int'(cnt) * LANES + k);
         lane_in[k] = work[idx[k]];
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      aes_sbox_fi u_sbox (
         .a   (lane_in[k]),
         .inv (inv),
         .c   (lane_out[k])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (bus.in_valid)  state_nx = RUN;
         RUN:     if (cnt == LAST)   state_nx = DONE;
         DONE:    if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: the work register is reset because it drives out_data directly and
   // must read as zero after reset, not just carry a valid qualifier.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         work <= '0;
         inv  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  work <= bus.in_data;
                  inv  <= bus.in_inv;
                  cnt  <= '0;
               end
            end
            RUN: begin
               for (int k = 0; k < LANES; k++) work[idx[k]] <= lane_out[k];
               cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state != IDLE);
   assign bus.out_data  = work;

endmodule

// File: doc/sub_bytes_iter.md
Name: sub_bytes_iter

Overview:
- Parametrised, sequential AES SubBytes engine for the 128-bit AES state.
- Time-multiplexes LANES byte S-boxes over the 16 state bytes: one 128-bit block takes 16/LANES cycles.
- Supports forward (encrypt) and inverse (decrypt) substitution, selected per block.
- Uses valid/ready handshakes on input and output, so it sits between round-key/ShiftRows stages in area-reduced AES-128 datapaths.

Parameters:
- LANES, 4, number of S-box instances processing bytes in parallel. Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration-time error.
- BEATS, 16/LANES, derived local constant. Cycles of substitution per block; not overridable.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input block offered.
- in_ready  output  1  engine can accept a block. High exactly when state is IDLE.
- in_data  input  128  input state; byte 0 = bits 127:120, byte 15 = bits 7:0.
- in_inv  input  1  0 = forward S-box, 1 = inverse S-box. Sampled with in_data.
- out_valid  output  1  result block available.
- out_ready  input  1  downstream accepts the result.
- out_data  output  128  substituted block, same byte order as in_data.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst=1): state=IDLE, beat counter=0, work register=0, mode register=0. Outputs: out_valid=0, out_data=0, busy=0. in_ready=1 once state is IDLE, including while rst is held.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: work register←in_data, mode←in_inv, counter←0, go to RUN.
  - in_valid without a transfer has no effect.
- RUN:
  - Each cycle, lane k (k=0..LANES-1) substitutes byte index counter*LANES+k of the work register in place, using the latched mode.
  - Counter increments by 1 each cycle.
  - When counter==BEATS-1, the final group is written, counter←0, and state→DONE.
  - in_ready=0; inputs are ignored.
- DONE:
  - out_valid=1. out_data and out_valid are held stable until out_ready=1.
  - On out_valid&out_ready: go to IDLE. out_data keeps its value; out_valid drops next cycle.
- Latency: acceptance edge at cycle T, out_valid high from cycle T+BEATS. LANES=16 gives 1 cycle; LANES=1 gives 16 cycles.
- Minimum initiation interval: BEATS+2 cycles (accept, BEATS run cycles, DONE handshake, IDLE). No overlap of input and output transfers.
- out_data is the work register directly. During RUN it shows partially substituted data. It is valid only while out_valid=1, and checkers sample it only then.
- Mode is frozen per block. Toggling in_inv after acceptance has no effect on the block in flight.
- Backpressure: out_ready low indefinitely keeps the block in DONE and in_ready=0; no data is lost or overwritten.
- Reset mid-RUN or mid-DONE: the block is discarded, all registers return to reset values, and no out_valid pulse is produced.
- Arithmetic:
  - Counter width is clog2(BEATS), minimum 1 bit.
  - For LANES=16 the counter is unused beyond the 0→DONE transition.
  - No wrap-around beyond BEATS-1 is permitted.

Decomposition:
- Shared package aes_pkg holds:
  - AES_BLOCK_W=128 and AES_NBYTES=16.
  - State encoding IDLE/RUN/DONE as a 2-bit enum.
  - The legal-LANES check function.
  - Forward and inverse S-box constant tables (256×8 each).
- One sub-module, aes_sbox_fi: combinational 8-bit S-box with an inv select (a=byte in, inv, c=byte out). It is instantiated LANES times via generate.

Test Plan:
- Forward FIPS-197 vector, LANES=4: in_data=193de3bea0f4e22b9ac68d2ae9f84808, in_inv=0 → after 4 cycles out_valid=1, out_data=d42711aee0bf98f1b8b45de51e415230.
- Inverse round-trip, LANES=1: in_data=d42711aee0bf98f1b8b45de51e415230, in_inv=1 → out_valid at T+16, out_data=193de3bea0f4e22b9ac68d2ae9f84808. Per-byte spot checks: S(00)=63, S(53)=ED, S(FF)=16; InvS(63)=00, InvS(ED)=53.
- Parameter sweep LANES∈{1,2,4,8,16}, same forward vector → identical out_data; out_valid rises exactly 16/LANES cycles after acceptance.
- Backpressure: hold out_ready=0 for 20 cycles in DONE, and toggle in_valid/in_inv/in_data → out_data stable, in_ready=0. Then out_ready=1 → single transfer, in_ready=1 next cycle.
- Reset mid-operation: assert rst during RUN beat 2 (LANES=4) → out_valid stays 0, out_data=0, busy=0, in_ready=1. The next block processes correctly.
- Back-to-back: in_valid held high, out_ready high, 3 blocks → each accepted in IDLE only, initiation interval exactly BEATS+2 cycles, outputs in order.
